// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of signals between the requesters/FIFO side (master) and the
// round-robin FIFO write arbiter (slave).
interface fifo_wr_arbiter_if #(
   parameter int N   = 4,
   parameter int D_W = 8
);
   logic [N-1:0]     req;
   logic [N*D_W-1:0] req_data;
   logic [N-1:0]     ack;
   logic [N-1:0]     grant;
   logic             fifo_full;
   logic             fifo_wren;
   logic [D_W-1:0]   fifo_din;
   logic             busy;
   logic [N*16-1:0]  stat_cnt;

   modport master (
      output req, req_data, fifo_full,
      input  ack, grant, fifo_wren, fifo_din, busy, stat_cnt
   );

   modport slave (
      input  req, req_data, fifo_full,
      output ack, grant, fifo_wren, fifo_din, busy, stat_cnt
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N requesters with
// bounded bursts. Optional per-requester word counters: FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
   parameter int N     = 4,
   parameter int D_W   = 8,
   parameter int BURST = 4
) (
   input  logic           clk,
   input  logic           rst,
   fifo_wr_arbiter_if.slave bus
);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W = $clog2(BURST) + 1;

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t           r_state;
   logic [N-1:0]     r_grant;
   logic [IDX_W-1:0] r_gidx;
   logic [IDX_W-1:0] r_rr_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;

   logic [IDX_W-1:0] w_pick;
   logic [IDX_W-1:0] w_next_ptr;
   logic             w_req_g;
   logic             w_xfer;
   logic             w_last;
   logic [N-1:0]     w_ack;
   logic [D_W-1:0]   w_din;

   // First requester at or above rr_ptr, wrapping mod N.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_pick = r_rr_ptr;
      for (int k = N - 1; k >= 0; k--) begin
         automatic int unsigned idx = (int'(r_rr_ptr) + k) % N;
         if (bus.req[idx]) w_pick = IDX_W'(idx);
      end
   end

   always_comb begin
      w_din   = '0;
      w_req_g = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (r_state == S_GRANT && IDX_W'(i) == r_gidx) begin
            w_din   = bus.req_data[i*D_W +: D_W];
            w_req_g = bus.req[i];
         end
      end
   end

   assign w_xfer     = (r_state == S_GRANT) & w_req_g & ~bus.fifo_full & ~rst;
   assign w_last     = (r_cnt == CNT_W'(BURST - 1));
   assign w_next_ptr = IDX_W'((int'(r_gidx) + 1) % N);
   assign w_ack      = w_xfer ? r_grant : '0;

   assign bus.ack       = w_ack;
   assign bus.grant     = r_grant;
   assign bus.fifo_wren = w_xfer;
   assign bus.fifo_din  = w_din;
   assign bus.busy      = r_busy;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_grant  <= '0;
         r_gidx   <= '0;
         r_rr_ptr <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|bus.req) begin
                  r_state <= S_GRANT;
                  r_grant <= N'(1) << w_pick;
                  r_gidx  <= w_pick;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_GRANT: begin
               // A dropped request releases even when the FIFO is full.
               if (!w_req_g || (w_xfer && w_last)) begin
                  r_state  <= S_IDLE;
                  r_grant  <= '0;
                  r_rr_ptr <= w_next_ptr;
                  r_busy   <= 1'b0;
               end else if (w_xfer) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_grant <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] r_stat [N];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) r_stat[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (w_ack[i] && r_stat[i] != 16'hFFFF) r_stat[i] <= r_stat[i] + 16'd1;
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_stat
      assign bus.stat_cnt[g*16 +: 16] = r_stat[g];
   end
`else
   assign bus.stat_cnt = '0;
`endif

endmodule
